// File: rtl/resp_rr_arbiter.sv
// Two-requester round-robin response arbiter with burst locking
// and a registered single-entry output stage.
module resp_rr_arbiter #(
    parameter int DATA_W = 32,
    parameter int SRC_W  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_0_valid,
    output logic              io_in_0_ready,
    input  logic [SRC_W-1:0]  io_in_0_bits_source,
    input  logic [DATA_W-1:0] io_in_0_bits_data,
    input  logic              io_in_0_bits_last,
    input  logic              io_in_1_valid,
    output logic              io_in_1_ready,
    input  logic [SRC_W-1:0]  io_in_1_bits_source,
    input  logic [DATA_W-1:0] io_in_1_bits_data,
    input  logic              io_in_1_bits_last,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [SRC_W-1:0]  io_out_bits_source,
    output logic [DATA_W-1:0] io_out_bits_data,
    output logic              io_out_bits_last,
    output logic              io_out_chosen
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED_0 = 2'd1,
        LOCKED_1 = 2'd2
    } lock_t;

    lock_t state;
    lock_t state_nxt;
    logic  prio;

    logic enq_ok;
    logic grant_0;
    logic grant_1;
    logic fire;
    logic sel;
    logic sel_last;

    assign enq_ok = !io_out_valid | io_out_ready;

    // A lock owner that goes idle keeps the lock; nobody is granted.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        unique case (1'b1)
            (state == LOCKED_0): grant_0 = io_in_0_valid;
            (state == LOCKED_1): grant_1 = io_in_1_valid;
            default: begin
                if (io_in_0_valid && io_in_1_valid) begin
                    grant_0 = !prio;
                    grant_1 = prio;
                end else begin
                    grant_0 = io_in_0_valid;
                    grant_1 = io_in_1_valid;
                end
            end
        endcase
    end

    assign io_in_0_ready = enq_ok & grant_0;
    assign io_in_1_ready = enq_ok & grant_1;

    assign fire     = io_in_0_ready | io_in_1_ready;
    assign sel      = grant_1;
    assign sel_last = sel ? io_in_1_bits_last : io_in_0_bits_last;

    always_comb begin
        state_nxt = state;
        if (fire) begin
            if (sel_last)
                state_nxt = UNLOCKED;
            else
                state_nxt = sel ? LOCKED_1 : LOCKED_0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= UNLOCKED;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            prio <= 1'b0;
        else if (fire && sel_last)
            prio <= ~sel;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_out_valid       <= 1'b0;
            io_out_bits_source <= '0;
            io_out_bits_data   <= '0;
            io_out_bits_last   <= 1'b0;
            io_out_chosen      <= 1'b0;
        end else if (fire) begin
            io_out_valid       <= 1'b1;
            io_out_bits_source <= sel ? io_in_1_bits_source
                                      : io_in_0_bits_source;
            io_out_bits_data   <= sel ? io_in_1_bits_data
                                      : io_in_0_bits_data;
            io_out_bits_last   <= sel_last;
            io_out_chosen      <= sel;
        end else if (io_out_ready) begin
            io_out_valid <= 1'b0;
        end
    end

endmodule
